dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single synchronous data-memory port between N_REQ requesters. Requester 0 is the core LSU path; the others are debug, DMA or a test loader.
- Grants at most one access per cycle using round-robin priority and drives the memory address, write-enable and write-data signals.
- Routes the read data returned one cycle later back to the granted requester, with a per-requester response strobe.
- Sits between the core and the data RAM. The RAM keeps its 1-cycle read latency and its byte-lane write enables.

Parameters:
- N_REQ, 2, number of requesters; legal range 2..4.
- AW, 32, address width.
- RR_INIT, 0, requester index that holds highest priority after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  N_REQ  per-requester access request.
- req_ready  out  N_REQ  grant; the access is accepted in the cycle where valid & ready.
- req_addr  in  N_REQ*AW  flattened request addresses; slot i is bits [i*AW +: AW].
- req_we  in  N_REQ*4  flattened byte write enables; all-zero means read.
- req_wdata  in  N_REQ*32  flattened write data.
- rsp_valid  out  N_REQ  one-cycle strobe marking completion of requester i's accepted access.
- rsp_rdata  out  32  read data, shared by all requesters; qualified by rsp_valid[i] and meaningful for reads only.
- d_addr  out  AW  memory address.
- d_we  out  4  memory byte write enables.
- d_wr_data  out  32  memory write data.
- d_rd_data  in  32  memory read data, valid the cycle after the address is presented.
- busy  out  1  a response is pending this cycle (registered).

Behaviour:
- Grant (combinational, same cycle):
  - Search starts at index rr_ptr and wraps modulo N_REQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1. The grant is one-hot or zero.
  - Ready depends on valid; a requester holds addr/we/wdata stable while valid && !ready.
- Memory drive:
  - d_addr, d_we and d_wr_data come from the granted slot.
  - With no grant: d_we=4'b0, d_addr=slot 0 address, d_wr_data=slot 0 data, so no spurious writes occur.
- Pointer update: on a cycle with a grant to index g, rr_ptr <= (g+1) mod N_REQ. With no grant, rr_ptr holds.
- Response pipeline (registered):
  - rsp_owner <= g and rsp_pend <= 1 on a grant; otherwise rsp_pend <= 0.
  - Next cycle: rsp_valid[rsp_owner] = rsp_pend; all other bits are 0.
  - rsp_rdata = d_rd_data, passed straight through (the RAM already registers it). It is driven even for writes; requesters ignore it after a write.
- Throughput and latency:
  - A new grant is allowed every cycle, back-to-back, including while a response is in flight. One access is in flight at most.
  - Latency is request accepted in cycle T, rsp_valid in cycle T+1.
- Reset values: rr_ptr=RR_INIT, rsp_pend=0, rsp_owner=0, rsp_valid=0, busy=0.
- Reset mid-operation: a pending response is dropped (rsp_valid stays 0) and no write is issued while rst is high. A write already presented before reset may have completed.
- Fairness boundaries:
  - Requester i waits at most N_REQ-1 grants while it holds valid.
  - With a single requester asserting every cycle, it is granted every cycle.
  - With all N_REQ requesters asserting continuously, the grant order is rr_ptr, rr_ptr+1, ... with wrap.
- Simultaneous events:
  - A grant to requester i and a rsp_valid for requester i can occur in the same cycle; they belong to different accesses.
  - Grant plus response to different requesters in the same cycle is legal.
- Assertions for the bench:
  - req_ready is one-hot or zero.
  - rsp_valid is one-hot or zero.
  - d_we is nonzero only if some req_ready is set.

Decomposition:
- Shared package: arbiter request typedef (addr, we, wdata), DMEM_RD_LATENCY=1, and requester index constants REQ_LSU=0, REQ_DBG=1.
- One natural sub-module: rr_arbiter, a combinational N-way round-robin pick from valid plus rr_ptr, producing a one-hot grant and an encoded index. The pointer register and response pipeline stay in dmem_arbiter.

Test Plan:
- Reset, then LSU read: req_valid=01, addr0=0x100; RAM[0x100]=0xDEADBEEF.
  - Required: req_ready=01 in the same cycle; next cycle rsp_valid=01, rsp_rdata=0xDEADBEEF; rr_ptr=1.
- Contention, both requesters valid for 4 cycles from rr_ptr=0.
  - Required: grants 0,1,0,1; rsp_valid follows one cycle later as 01,10,01,10.
- Byte write: req1 we=4'b0001, addr=0x20, wdata=0x000000AB.
  - Required: d_we=0001 and d_addr=0x20 in the grant cycle; rsp_valid=10 the next cycle; a later read of 0x20 returns low byte 0xAB with other bytes unchanged.
- Idle: req_valid=00 for 3 cycles.
  - Required: d_we=0000, req_ready=00, rsp_valid=00, rr_ptr unchanged.
- Reset mid-access: grant a read to req0, assert rst the next cycle.
  - Required: rsp_valid=00, busy=0, rr_ptr=RR_INIT; the first post-reset grant goes to RR_INIT when both requesters are valid.
- Back-to-back single requester: req1 valid for 5 cycles with addresses 0x0,0x4,0x8,0xC,0x10.
  - Required: req_ready[1]=1 every cycle; 5 consecutive rsp_valid=10 pulses with data in address order.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_arbiter_pkg;

    localparam int unsigned DATA_W          = 32;
    localparam int unsigned BE_W            = 4;
    localparam int unsigned ADDR_W_MAX      = 32;
    localparam int unsigned DMEM_RD_LATENCY = 1;

    localparam int unsigned REQ_LSU = 0;
    localparam int unsigned REQ_DBG = 1;

    typedef struct packed {
        logic [ADDR_W_MAX-1:0] addr;
        logic [BE_W-1:0]       we;
        logic [DATA_W-1:0]     wdata;
    } arb_req_t;

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Combinational round-robin pick: first valid index at or after ptr, wrapping.
module rr_arbiter #(
    parameter  int unsigned N  = 2,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_any
);

    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (!grant_any && valid[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
                grant_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin sharing of the single synchronous data-memory port between
// N_REQ requesters, with a one-cycle response strobe back to the winner.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned AW      = 32,
    parameter int unsigned RR_INIT = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*AW-1:0]    req_addr,
    input  logic [N_REQ*BE_W-1:0]  req_we,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic [AW-1:0]          d_addr,
    output logic [BE_W-1:0]        d_we,
    output logic [DATA_W-1:0]      d_wr_data,
    input  logic [DATA_W-1:0]      d_rd_data,
    output logic                   busy
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_req_t          slot [N_REQ];
    arb_req_t          sel;
    logic [N_REQ-1:0]  valid_gated;
    logic [N_REQ-1:0]  grant;
    logic [IW-1:0]     grant_idx;
    logic              grant_any;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     ptr_next;
    logic              rsp_pend;

    for (genvar i = 0; i < N_REQ; i++) begin : g_slot
        assign slot[i].addr  = ADDR_W_MAX'(req_addr[i*AW +: AW]);
        assign slot[i].we    = req_we[i*BE_W +: BE_W];
        assign slot[i].wdata = req_wdata[i*DATA_W +: DATA_W];
    end

    // Nothing is granted (so nothing is written) while reset is held.
    assign valid_gated = rst ? '0 : req_valid;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .valid     (valid_gated),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign req_ready = grant;
    assign ptr_next  = IW'((32'(grant_idx) + 32'd1) % N_REQ);

    // Idle cycles park the port on the LSU slot with write enables low.
    always_comb begin
        sel       = grant_any ? slot[grant_idx] : slot[REQ_LSU];
        d_addr    = AW'(sel.addr);
        d_wr_data = sel.wdata;
        d_we      = grant_any ? sel.we : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= IW'(RR_INIT);
            rsp_pend  <= 1'b0;
            rsp_valid <= '0;
        end else begin
            rsp_pend  <= grant_any;
            rsp_valid <= grant;
            if (grant_any) begin
                rr_ptr <= ptr_next;
            end
        end
    end

    // The RAM already registers its read data; pass it straight back.
    assign rsp_rdata = d_rd_data;
    assign busy      = rsp_pend;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1-cycle RAM and a
// response scoreboard fed from a reference copy of memory.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_addr;
    logic [7:0]  req_we;
    logic [63:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic [31:0] d_addr;
    logic [3:0]  d_we;
    logic [31:0] d_wr_data;
    logic [31:0] d_rd_data;
    logic        busy;

    logic [31:0] a [2];
    logic [3:0]  w [2];
    logic [31:0] d [2];

    logic [31:0] ram     [256];
    logic [31:0] ref_mem [256];

    typedef struct {
        int          owner;
        bit          is_rd;
        logic [31:0] data;
    } exp_t;
    exp_t sb [$];

    int checks = 0;
    int errors = 0;

    assign req_addr  = {a[1], a[0]};
    assign req_we    = {w[1], w[0]};
    assign req_wdata = {d[1], d[0]};

    dmem_arbiter #(.N_REQ(2), .AW(32), .RR_INIT(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .d_addr    (d_addr),
        .d_we      (d_we),
        .d_wr_data (d_wr_data),
        .d_rd_data (d_rd_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: byte-lane writes, read data one cycle after the address.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (d_we[b]) ram[d_addr[9:2]][b*8 +: 8] <= d_wr_data[b*8 +: 8];
        end
        d_rd_data <= ram[d_addr[9:2]];
    end

    always @(negedge clk) begin
        if (!rst) begin
            checks += 3;
            assert ($onehot0(req_ready)) else begin
                errors++;
                $error("FAIL ready_onehot: observed %b expected one-hot or zero", req_ready);
            end
            assert ($onehot0(rsp_valid)) else begin
                errors++;
                $error("FAIL rsp_onehot: observed %b expected one-hot or zero", rsp_valid);
            end
            assert (d_we == 4'b0 || req_ready != 2'b0) else begin
                errors++;
                $error("FAIL we_without_grant: observed d_we=%b ready=%b", d_we, req_ready);
            end
        end
    end

    function automatic logic [31:0] init_word(input int i);
        if (i == 'h40) return 32'hDEADBEEF;
        if (i == 'h08) return 32'h11223344;
        return {8'hA5, 8'h00, 16'(i * 4)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_slot(input int s, input logic [31:0] addr, input logic [3:0] we,
                            input logic [31:0] wdata);
        a[s] = addr;
        w[s] = we;
        d[s] = wdata;
    endtask

    // One cycle: drive valid, check last cycle's response and this cycle's grant.
    task automatic step(input logic [1:0] v, input logic [1:0] exp_rdy);
        exp_t e;
        int   g;
        req_valid = v;
        #3;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rsp_valid", 32'(rsp_valid), 32'(2'b01 << e.owner));
            chk("busy", 32'(busy), 32'd1);
            if (e.is_rd) chk("rsp_rdata", rsp_rdata, e.data);
        end else begin
            chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
            chk("busy_idle", 32'(busy), 32'd0);
        end
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (exp_rdy != 2'b00) begin
            g = exp_rdy[1] ? 1 : 0;
            chk("d_addr", d_addr, a[g]);
            chk("d_we", 32'(d_we), 32'(w[g]));
            e.owner = g;
            e.is_rd = (w[g] == 4'b0);
            e.data  = ref_mem[a[g][9:2]];
            if (!e.is_rd) begin
                chk("d_wr_data", d_wr_data, d[g]);
                for (int b = 0; b < 4; b++)
                    if (w[g][b]) ref_mem[a[g][9:2]][b*8 +: 8] = d[g][b*8 +: 8];
            end
            sb.push_back(e);
        end else begin
            chk("d_we_idle", 32'(d_we), 32'd0);
            chk("d_addr_idle", d_addr, a[0]);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]     <= init_word(i);
            ref_mem[i]  = init_word(i);
        end
        rst       = 1'b1;
        req_valid = 2'b00;
        set_slot(0, 32'h0, 4'b0, 32'h0);
        set_slot(1, 32'h0, 4'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // LSU read of 0x100
        set_slot(0, 32'h100, 4'b0, 32'h0);
        step(2'b01, 2'b01);

        // Contention from rr_ptr=1
        set_slot(1, 32'h200, 4'b0, 32'h0);
        step(2'b11, 2'b10);
        step(2'b11, 2'b01);
        step(2'b11, 2'b10);
        step(2'b11, 2'b01);

        // Byte write from requester 1
        set_slot(1, 32'h20, 4'b0001, 32'h000000AB);
        step(2'b10, 2'b10);

        // Contention from rr_ptr=0
        set_slot(1, 32'h24, 4'b0, 32'h0);
        step(2'b11, 2'b01);
        step(2'b11, 2'b10);
        step(2'b11, 2'b01);
        step(2'b11, 2'b10);

        // Read back the byte-written word
        set_slot(0, 32'h20, 4'b0, 32'h0);
        step(2'b01, 2'b01);
        chk("byte_merge", ref_mem[8], 32'h112233AB);

        // Idle, then pointer must still favour requester 1
        step(2'b00, 2'b00);
        step(2'b00, 2'b00);
        step(2'b00, 2'b00);
        step(2'b11, 2'b10);

        // Back-to-back single requester
        for (int k = 0; k < 5; k++) begin
            set_slot(1, 32'(k * 4), 4'b0, 32'h0);
            step(2'b10, 2'b10);
        end
        step(2'b00, 2'b00);

        // Reset while a read response is in flight
        set_slot(0, 32'h100, 4'b0, 32'h0);
        step(2'b01, 2'b01);
        rst       = 1'b1;
        req_valid = 2'b00;
        #3;
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_d_we", 32'(d_we), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_slot(1, 32'h200, 4'b0, 32'h0);
        step(2'b11, 2'b01);
        step(2'b00, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
